// File: rtl/byte_frame_pkg.sv
// ---------------------------------------------------------------------------
// byte_frame_pkg
// Shared definitions for the byte frame sender slice.
//   frame_state_t      : controller state encoding (IDLE, SEND)
//   DEFAULT_NUM_BYTES  : default number of bytes in one frame word
//   DEFAULT_BYTE_W     : default width of one byte lane
//   DEFAULT_MSB_FIRST  : default send order (0 = lane 0 first)
// ---------------------------------------------------------------------------
package byte_frame_pkg;

  // IDLE waits for a frame; SEND is presenting bytes of the active frame.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } frame_state_t;

  localparam int DEFAULT_NUM_BYTES = 5;
  localparam int DEFAULT_BYTE_W    = 8;
  localparam int DEFAULT_MSB_FIRST = 0;

  // Width of a counter that walks 0 .. num_bytes-1.
  // Never returns less than 1 so the index port always exists.
  function automatic int index_width(input int num_bytes);
    int w;
    w = $clog2(num_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/byte_lane_select.sv
// ---------------------------------------------------------------------------
// byte_lane_select
// Purely combinational picker that returns one byte lane of a frame word.
//   word      in  NUM_BYTES*BYTE_W  frame word, lane 0 in the low bits
//   index     in  IDX_W             position in send order, 0-based
//   lane_byte out BYTE_W            selected lane (0 for an out-of-range index)
// With MSB_FIRST=0 position k maps to lane k; with MSB_FIRST=1 position k
// maps to lane NUM_BYTES-1-k, so the highest lane goes out first.
// ---------------------------------------------------------------------------
module byte_lane_select
  import byte_frame_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int BYTE_W    = DEFAULT_BYTE_W,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST,
  parameter int IDX_W     = index_width(NUM_BYTES)
) (
  input  logic [NUM_BYTES*BYTE_W-1:0] word,
  input  logic [IDX_W-1:0]            index,
  output logic [BYTE_W-1:0]           lane_byte
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  logic [IDX_W-1:0] lane_sel;

  // Translate the send-order position into a physical lane number.
  // The reversed order is a plain subtraction from the last lane.
  always_comb begin
    lane_sel = index;
    if (MSB_FIRST != 0) begin
      lane_sel = LAST_IDX - index;
    end
  end

  // Mux the chosen lane out with a compare-per-lane loop rather than a
  // variable part-select, so an index past the last lane cleanly gives 0.
  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (lane_sel == IDX_W'(i)) begin
        lane_byte = word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/byte_frame_sender.sv
// ---------------------------------------------------------------------------
// byte_frame_sender
// Accepts whole frame words and hands them to a byte-wide transmitter one
// byte at a time, with a single pending slot so back-to-back frames stream
// without a gap.
//   clk         in  rising-edge clock
//   rst_n       in  asynchronous active-low reset
//   data_in     in  NUM_BYTES*BYTE_W frame word, captured only on accepted load
//   load        in  frame request, accepted when load_ready=1
//   load_ready  out pending slot is empty
//   byte_done   in  downstream consumed the current byte_out
//   abort       in  synchronous flush of active and pending frames
//   byte_out    out current byte (0 when byte_valid=0)
//   byte_valid  out byte_out holds a frame byte
//   byte_index  out position of byte_out in send order
//   busy        out controller is in SEND
//   frame_done  out one-cycle pulse after the last byte of a frame is consumed
// ---------------------------------------------------------------------------
module byte_frame_sender
  import byte_frame_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int BYTE_W    = DEFAULT_BYTE_W,
  parameter int MSB_FIRST = DEFAULT_MSB_FIRST
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_BYTES*BYTE_W-1:0]       data_in,
  input  logic                              load,
  output logic                              load_ready,
  input  logic                              byte_done,
  input  logic                              abort,
  output logic [BYTE_W-1:0]                 byte_out,
  output logic                              byte_valid,
  output logic [index_width(NUM_BYTES)-1:0] byte_index,
  output logic                              busy,
  output logic                              frame_done
);

  localparam int               IDX_W    = index_width(NUM_BYTES);
  localparam int               WORD_W   = NUM_BYTES * BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  frame_state_t      state_q, state_d;
  logic [WORD_W-1:0] active_q, active_d;
  logic [WORD_W-1:0] pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic              frame_done_q, frame_done_d;

  logic              load_accept;
  logic              last_byte;
  logic [BYTE_W-1:0] lane_byte;

  // A load is only taken while the pending slot has room. In IDLE the slot
  // is always empty, so load_ready is 1 there without a special case.
  assign load_ready  = ~pending_full_q;
  assign load_accept = load & ~pending_full_q;
  assign last_byte   = byte_done & (index_q == LAST_IDX);

  // Next-state and datapath decisions. Abort is checked first so it wins
  // over load and byte_done, and it never raises frame_done. On the final
  // byte a queued frame is promoted ahead of a same-edge load (the load
  // cannot be accepted then anyway, because the slot is full); with the
  // slot empty a same-edge load goes straight into the active register.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    index_d        = index_q;
    frame_done_d   = 1'b0;

    if (abort) begin
      state_d        = IDLE;
      pending_full_d = 1'b0;
      index_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_accept) begin
            active_d = data_in;
            index_d  = '0;
            state_d  = SEND;
          end
        end
        SEND: begin
          if (last_byte) begin
            frame_done_d = 1'b1;
            index_d      = '0;
            if (pending_full_q) begin
              active_d       = pending_q;
              pending_full_d = 1'b0;
            end else if (load_accept) begin
              active_d = data_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (byte_done) begin
              index_d = index_q + IDX_W'(1);
            end
            if (load_accept) begin
              pending_d      = data_in;
              pending_full_d = 1'b1;
            end
          end
        end
        default: begin
          state_d        = IDLE;
          pending_full_d = 1'b0;
          index_d        = '0;
        end
      endcase
    end
  end

  // State and datapath registers. Everything is cleared by reset so a frame
  // interrupted by rst_n is fully forgotten and the next one starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      index_q        <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      index_q        <= index_d;
      frame_done_q   <= frame_done_d;
    end
  end

  byte_lane_select #(
    .NUM_BYTES (NUM_BYTES),
    .BYTE_W    (BYTE_W),
    .MSB_FIRST (MSB_FIRST),
    .IDX_W     (IDX_W)
  ) u_lane_select (
    .word      (active_q),
    .index     (index_q),
    .lane_byte (lane_byte)
  );

  // Outputs decode straight from registered state, so an asserted rst_n
  // forces them to their idle values without waiting for a clock edge.
  assign busy       = (state_q == SEND);
  assign byte_valid = busy;
  assign byte_index = index_q;
  assign frame_done = frame_done_q;
  assign byte_out   = byte_valid ? lane_byte : '0;

endmodule
